// File: rtl/axi_stream_sink_fifo.sv
// AXI-Stream receive FIFO: registered tready, beats popped on a valid/ready port one edge after storage.
// Backpressure: tready drops once the edge's next level reaches DEPTH; optional checker (AXI_STREAM_SINK_PROTOCOL_CHECK_EN).
module axi_stream_sink_fifo #(
    parameter int TDATA_WIDTH = 32,
    parameter int TUSER_WIDTH = 1,
    parameter int DEPTH       = 8,
    parameter int DROP_NULL   = 1
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         tvalid,
    output logic                         tready,
    input  logic [TDATA_WIDTH-1:0]       tdata,
    input  logic [TDATA_WIDTH/8-1:0]     tkeep,
    input  logic                         tlast,
    input  logic [TUSER_WIDTH-1:0]       tuser,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [TDATA_WIDTH-1:0]       rd_data,
    output logic [TDATA_WIDTH/8-1:0]     rd_keep,
    output logic                         rd_last,
    output logic [TUSER_WIDTH-1:0]       rd_user,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [$clog2(DEPTH+1)-1:0]   pkt_count,
    output logic                         err_stall,
    output logic                         err_drop,
    input  logic                         err_clr
);
    localparam int KW = TDATA_WIDTH / 8;
    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    if (TDATA_WIDTH % 8 != 0) begin : g_bad_width
        $fatal(1, "TDATA_WIDTH must be a multiple of 8");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "DEPTH must be a power of two, at least 2");
    end
    if (TUSER_WIDTH < 1) begin : g_bad_user
        $fatal(1, "TUSER_WIDTH must be at least 1");
    end

    typedef struct packed {
        logic [TDATA_WIDTH-1:0] data;
        logic [KW-1:0]          keep;
        logic                   last;
        logic [TUSER_WIDTH-1:0] user;
    } beat_t;

    beat_t          mem_q [DEPTH];
    beat_t          in_beat;
    beat_t          head;
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]  level_q, level_d;
    logic [LW-1:0]  pkt_q, pkt_d;
    logic           tready_q, tready_d;
    logic           accept, is_null, store, pop, push_last, pop_last;

    assign in_beat   = '{data: tdata, keep: tkeep, last: tlast, user: tuser};
    assign head      = mem_q[rd_ptr_q];
    assign accept    = tvalid & tready_q;
    assign is_null   = (tkeep == '0) & ~tlast;
    // Null beats are still handshaken so the transmitter never stalls on them.
    assign store     = accept & ~((DROP_NULL != 0) & is_null);
    assign rd_valid  = (level_q != '0);
    assign pop       = rd_valid & rd_ready;
    assign push_last = store & tlast;
    assign pop_last  = pop & head.last;

    always_comb begin
        level_d = level_q;
        if (store && !pop)
            level_d = level_q + LW'(1);
        else if (pop && !store)
            level_d = level_q - LW'(1);
        pkt_d = pkt_q;
        if (push_last && !pop_last)
            pkt_d = pkt_q + LW'(1);
        else if (pop_last && !push_last)
            pkt_d = pkt_q - LW'(1);
        tready_d = (level_d < LW'(DEPTH));
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            pkt_q    <= '0;
            tready_q <= 1'b0;
        end else begin
            level_q  <= level_d;
            pkt_q    <= pkt_d;
            tready_q <= tready_d;
            if (store)
                wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (store)
            mem_q[wr_ptr_q] <= in_beat;
    end

    assign tready    = tready_q;
    assign level     = level_q;
    assign pkt_count = pkt_q;
    assign rd_data   = head.data;
    assign rd_keep   = head.keep;
    assign rd_last   = head.last;
    assign rd_user   = head.user;

`ifdef AXI_STREAM_SINK_PROTOCOL_CHECK_EN
    logic  stall_q;
    beat_t prev_q;
    logic  err_stall_q, err_drop_q;
    logic  set_stall, set_drop;

    // stall_q marks a cycle whose beat the transmitter was obliged to hold.
    assign set_stall = stall_q & tvalid & (in_beat != prev_q);
    assign set_drop  = stall_q & ~tvalid;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stall_q     <= 1'b0;
            prev_q      <= '0;
            err_stall_q <= 1'b0;
            err_drop_q  <= 1'b0;
        end else begin
            stall_q     <= tvalid & ~tready_q;
            prev_q      <= in_beat;
            err_stall_q <= set_stall | (err_stall_q & ~err_clr);
            err_drop_q  <= set_drop  | (err_drop_q  & ~err_clr);
        end
    end

    assign err_stall = err_stall_q;
    assign err_drop  = err_drop_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_stall      = 1'b0;
    assign err_drop       = 1'b0;
`endif

endmodule

// File: tb/tb_axi_stream_sink_fifo.sv
// Scoreboard bench for axi_stream_sink_fifo (DEPTH=8, 32-bit data, DROP_NULL=1).
module tb_axi_stream_sink_fifo;
    logic        aclk = 1'b0;
    logic        aresetn;
    logic        tvalid, tready, tlast, rd_valid, rd_ready, rd_last;
    logic [31:0] tdata, rd_data;
    logic [3:0]  tkeep, rd_keep, level, pkt_count;
    logic [0:0]  tuser, rd_user;
    logic        err_stall, err_drop, err_clr;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        logic [0:0]  u;
    } beat_t;

    beat_t sb[$];
    int    m_level = 0;
    int    m_pkt   = 0;
    logic  m_tready = 1'b0;

`ifdef AXI_STREAM_SINK_PROTOCOL_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    axi_stream_sink_fifo #(.TDATA_WIDTH(32), .TUSER_WIDTH(1), .DEPTH(8), .DROP_NULL(1)) dut (
        .aclk(aclk), .aresetn(aresetn), .tvalid(tvalid), .tready(tready),
        .tdata(tdata), .tkeep(tkeep), .tlast(tlast), .tuser(tuser),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_keep(rd_keep),
        .rd_last(rd_last), .rd_user(rd_user), .level(level), .pkt_count(pkt_count),
        .err_stall(err_stall), .err_drop(err_drop), .err_clr(err_clr)
    );

    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // Reference model: evaluated mid-cycle, predicts the state after the coming edge.
    always @(negedge aclk) begin
        beat_t exp_b;
        logic  m_pop, m_store, e_last;
        if (!aresetn) begin
            sb.delete();
            m_level  = 0;
            m_pkt    = 0;
            m_tready = 1'b0;
        end else begin
            checks++;
            if (tready !== m_tready) begin
                errors++;
                $display("FAIL tready: got %0b expected %0b", tready, m_tready);
            end
            checks++;
            if (level !== 4'(m_level)) begin
                errors++;
                $display("FAIL level: got %0d expected %0d", level, m_level);
            end
            checks++;
            if (pkt_count !== 4'(m_pkt)) begin
                errors++;
                $display("FAIL pkt_count: got %0d expected %0d", pkt_count, m_pkt);
            end
            checks++;
            if (rd_valid !== (m_level != 0)) begin
                errors++;
                $display("FAIL rd_valid: got %0b expected %0b", rd_valid, m_level != 0);
            end
            m_pop   = (m_level != 0) && rd_ready;
            m_store = tvalid && m_tready && !(tkeep == 4'h0 && !tlast);
            e_last  = 1'b0;
            if (m_pop) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL pop_underflow: got pop expected empty scoreboard to have data");
                end else begin
                    exp_b  = sb.pop_front();
                    e_last = exp_b.l;
                    if ({rd_data, rd_keep, rd_last, rd_user} !== exp_b) begin
                        errors++;
                        $display("FAIL pop_data: got %h/%h/%b/%b expected %h/%h/%b/%b",
                                 rd_data, rd_keep, rd_last, rd_user, exp_b.d, exp_b.k, exp_b.l, exp_b.u);
                    end
                end
            end
            if (m_store)
                sb.push_back('{d: tdata, k: tkeep, l: tlast, u: tuser});
            m_level  = m_level + int'(m_store) - int'(m_pop);
            m_pkt    = m_pkt + int'(m_store && tlast) - int'(m_pop && e_last);
            m_tready = (m_level < 8);
        end
    end

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive(input logic [31:0] d, input logic [3:0] k, input logic l);
        tvalid = 1'b1;
        tdata  = d;
        tkeep  = k;
        tlast  = l;
        tuser  = d[0];
    endtask

    task automatic drain();
        tvalid   = 1'b0;
        rd_ready = 1'b1;
        for (int i = 0; i < 40 && level != 0; i++)
            cyc();
        rd_ready = 1'b0;
        checks++;
        if (level !== 4'd0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain: got level %0d rd_valid %0b expected 0 and 0", level, rd_valid);
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0; rd_ready = 1'b0; err_clr = 1'b0;
        drive(32'hAA, 4'hF, 1'b0);
        repeat (3) cyc();
        checks++;
        if ({tready, rd_valid, level, pkt_count, err_stall, err_drop} !== 12'h0) begin
            errors++;
            $display("FAIL reset_state: got tready %0b rd_valid %0b level %0d pkt %0d errs %0b%0b expected all 0",
                     tready, rd_valid, level, pkt_count, err_stall, err_drop);
        end
        aresetn = 1'b1;
        #2;
        checks++;
        if (tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_tready: got %0b expected 0", tready);
        end
        cyc();
        checks++;
        if (tready !== 1'b1 || level !== 4'd0) begin
            errors++;
            $display("FAIL reset_first_edge: got tready %0b level %0d expected 1 and 0", tready, level);
        end
        tvalid = 1'b0;
    endtask

    task automatic test_fill_drain();
        rd_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(32'(i), 4'hF, 1'b0);
            cyc();
        end
        tvalid = 1'b0;
        checks++;
        if (level !== 4'd8 || tready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: got level %0d tready %0b expected 8 and 0", level, tready);
        end
        rd_ready = 1'b1;
        cyc();
        checks++;
        if (tready !== 1'b1 || level !== 4'd7) begin
            errors++;
            $display("FAIL first_pop_tready: got tready %0b level %0d expected 1 and 7", tready, level);
        end
        drain();
    endtask

    task automatic test_packets();
        rd_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            drive(32'h10 + 32'(i), 4'hF, (i == 3 || i == 6));
            cyc();
        end
        tvalid = 1'b0;
        checks++;
        if (pkt_count !== 4'd2 || level !== 4'd6) begin
            errors++;
            $display("FAIL pkt_two: got pkt %0d level %0d expected 2 and 6", pkt_count, level);
        end
        rd_ready = 1'b1;
        repeat (3) cyc();
        rd_ready = 1'b0;
        checks++;
        if (pkt_count !== 4'd1 || level !== 4'd3) begin
            errors++;
            $display("FAIL pkt_after_pop: got pkt %0d level %0d expected 1 and 3", pkt_count, level);
        end
        rd_ready = 1'b1;
        repeat (2) cyc();
        checks++;
        if (rd_last !== 1'b1 || rd_data !== 32'h16) begin
            errors++;
            $display("FAIL pkt_head_last: got last %0b data %h expected 1 and 00000016", rd_last, rd_data);
        end
        drive(32'h20, 4'hF, 1'b1);
        cyc();
        tvalid = 1'b0; rd_ready = 1'b0;
        checks++;
        if (pkt_count !== 4'd1 || level !== 4'd1) begin
            errors++;
            $display("FAIL pkt_same_edge: got pkt %0d level %0d expected 1 and 1", pkt_count, level);
        end
        drain();
        checks++;
        if (pkt_count !== 4'd0) begin
            errors++;
            $display("FAIL pkt_drained: got %0d expected 0", pkt_count);
        end
    endtask

    task automatic test_null();
        rd_ready = 1'b0;
        drive(32'h33, 4'h0, 1'b0);
        cyc();
        tvalid = 1'b0;
        checks++;
        if (level !== 4'd0 || tready !== 1'b1) begin
            errors++;
            $display("FAIL null_dropped: got level %0d tready %0b expected 0 and 1", level, tready);
        end
        drive(32'h55, 4'h0, 1'b1);
        cyc();
        tvalid = 1'b0;
        checks++;
        if (level !== 4'd1 || rd_valid !== 1'b1 || rd_last !== 1'b1 || rd_keep !== 4'h0 || rd_data !== 32'h55) begin
            errors++;
            $display("FAIL null_last_kept: got level %0d valid %0b last %0b keep %h data %h expected 1 1 1 0 00000055",
                     level, rd_valid, rd_last, rd_keep, rd_data);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic        acc;
        rd_ready = 1'b0;
        d = 32'h100;
        for (int i = 0; i < 8; i++) begin
            drive(d, 4'hF, d[1]);
            cyc();
            d++;
        end
        rd_ready = 1'b1;
        drive(d, 4'hF, d[1]);
        for (int i = 0; i < 20; i++) begin
            acc = tready;
            cyc();
            checks++;
            if (level !== 4'd7 && level !== 4'd8) begin
                errors++;
                $display("FAIL b2b_level: got %0d expected 7 or 8", level);
            end
            if (acc) begin
                d++;
                drive(d, 4'hF, d[1]);
            end
        end
        drain();
    endtask

    task automatic test_protocol();
        rd_ready = 1'b0; err_clr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(32'h200 + 32'(i), 4'hF, 1'b0);
            cyc();
        end
        drive(32'hDEAD, 4'hF, 1'b0);
        cyc();
        drive(32'hBEEF, 4'hF, 1'b0);
        cyc();
        checks++;
        if (err_stall !== EXP_ERR || err_drop !== 1'b0) begin
            errors++;
            $display("FAIL err_stall_set: got stall %0b drop %0b expected %0b and 0", err_stall, err_drop, EXP_ERR);
        end
        tvalid = 1'b0;
        cyc();
        checks++;
        if (err_drop !== EXP_ERR || err_stall !== EXP_ERR) begin
            errors++;
            $display("FAIL err_drop_set: got drop %0b stall %0b expected %0b and %0b", err_drop, err_stall, EXP_ERR, EXP_ERR);
        end
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        checks++;
        if (err_stall !== 1'b0 || err_drop !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got stall %0b drop %0b expected 0 and 0", err_stall, err_drop);
        end
        drive(32'h77, 4'hF, 1'b0);
        cyc();
        tvalid = 1'b0; err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        checks++;
        if (err_drop !== EXP_ERR || err_stall !== 1'b0) begin
            errors++;
            $display("FAIL err_set_wins: got drop %0b stall %0b expected %0b and 0", err_drop, err_stall, EXP_ERR);
        end
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        drain();
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_packets();
        test_null();
        test_back_to_back();
        test_protocol();
        repeat (2) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
